// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state codes and default timing for the ALU sequencer.
package alu_seq_pkg;

    localparam int MUL_CYCLES_DEF = 32;
    localparam int ALU_LAT_DEF    = 1;

    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLL   = 6'b000010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_IDLE  = 6'b000000;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RUN_ALU   = 3'd1;
    localparam state_t ST_RUN_MUL   = 3'd2;
    localparam state_t ST_MUL_LATCH = 3'd3;
    localparam state_t ST_RESP      = 3'd4;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL,
            OP_MULTU, OP_MFHI, OP_MFLO: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_counter.sv
// Latency counter: clears on request, counts while enabled, saturates at the terminal value.
module alu_seq_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = (count == last);

    // Holding at the terminal value keeps the counter from ever wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer that drives an external ALU datapath and times its
// single-cycle, multiply and HI/LO-move operations.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int ALU_LAT    = ALU_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [5:0]  alu_signal,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        hilo_valid
);

    localparam int CNT_MAX = (MUL_CYCLES > ALU_LAT) ? MUL_CYCLES : ALU_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t           state;
    state_t           state_n;
    logic [5:0]       op;
    logic             xfer;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_last;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign xfer      = req_valid && req_ready;
    assign cnt_en    = (state == ST_RUN_ALU) || (state == ST_RUN_MUL);
    assign cnt_last  = (state == ST_RUN_MUL) ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(ALU_LAT - 1);

    alu_seq_counter #(.W(CNT_W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (xfer),
        .en    (cnt_en),
        .last  (cnt_last),
        .tc    (cnt_tc)
    );

    // Illegal opcodes never reach a RUN state, so the datapath only sees legal codes.
    always_comb begin
        alu_signal = OP_IDLE;
        if (state == ST_RUN_ALU || state == ST_RUN_MUL || state == ST_MUL_LATCH) begin
            alu_signal = op;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!op_legal(req_op))       state_n = ST_RESP;
                    else if (req_op == OP_MULTU) state_n = ST_RUN_MUL;
                    else                         state_n = ST_RUN_ALU;
                end
            end
            ST_RUN_ALU:   if (cnt_tc) state_n = ST_RESP;
            ST_RUN_MUL:   if (cnt_tc) state_n = ST_MUL_LATCH;
            ST_MUL_LATCH: state_n = ST_RESP;
            ST_RESP:      if (rsp_ready) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op         <= OP_IDLE;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            hilo_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (xfer) begin
                op        <= req_op;
                alu_dataA <= req_a;
                alu_dataB <= req_b;
                rsp_data  <= '0;
                rsp_err   <= !op_legal(req_op);
            end
            if (state == ST_RUN_ALU && cnt_tc) begin
                rsp_data <= alu_result;
            end
            if (state == ST_MUL_LATCH) begin
                hilo_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: emulated ALU datapath, transaction-level reference
// model with per-cycle comparison, directed literal cases and random traffic.
module tb_alu_sequencer;

    localparam int MUL = 32;
    localparam int LAT = 1;

    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLL   = 6'b000010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    localparam logic [5:0] OPS [11] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL,
                                        OP_MULTU, OP_MFHI, OP_MFLO, OP_BAD, 6'b000000};

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        hilo_valid;

    alu_sequencer #(.MUL_CYCLES(MUL), .ALU_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_signal (alu_signal),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .hilo_valid (hilo_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:  return a << b[4:0];
            OP_MFHI: return hi;
            OP_MFLO: return lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        for (int i = 0; i < 9; i++) if (OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Emulated datapath: combinational result, HI/LO written after MUL+1 MULTU cycles.
    logic [31:0] dp_hi = 32'd0;
    logic [31:0] dp_lo = 32'd0;
    int          mcnt  = 0;

    always_comb alu_result = alu_fn(alu_signal, alu_dataA, alu_dataB, dp_hi, dp_lo);

    always @(posedge clk) begin
        if (alu_signal == OP_MULTU) begin
            if (mcnt == MUL) {dp_hi, dp_lo} <= {32'd0, alu_dataA} * {32'd0, alu_dataB};
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
        end
    end

    // Reference model: elapsed cycles since accept versus required latency.
    bit          m_busy = 0;
    int          m_cyc  = 0;
    int          m_lat  = 0;
    logic [5:0]  m_op   = 6'd0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic        m_err  = 1'b0;
    logic        m_hv   = 1'b0;
    bit          acc_flag = 0;
    bit          chk_en   = 0;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [63:0] prod;
        acc_flag = 0;
        if (!reset) begin
            m_busy = 0; m_cyc = 0; m_lat = 0; m_op = 6'd0; m_a = 32'd0; m_b = 32'd0;
            m_data = 32'd0; m_err = 1'b0; m_hv = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                acc_flag = 1;
                m_busy   = 1;
                m_cyc    = 1;
                m_op     = req_op;
                m_a      = req_a;
                m_b      = req_b;
                m_err    = !is_legal(req_op);
                m_lat    = m_err ? 1 : ((req_op == OP_MULTU) ? MUL + 2 : LAT + 1);
                m_data   = m_err ? 32'd0 : alu_fn(req_op, req_a, req_b, m_hi, m_lo);
            end
        end else if (m_cyc < m_lat) begin
            m_cyc++;
            if (m_cyc == m_lat && m_op == OP_MULTU) begin
                m_hv = 1'b1;
                prod = {32'd0, m_a} * {32'd0, m_b};
                m_hi = prod[63:32];
                m_lo = prod[31:0];
            end
        end else if (rsp_ready) begin
            m_busy = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic exp_rv;
            logic [5:0] exp_sig;
            exp_rv  = m_busy && (m_cyc >= m_lat);
            exp_sig = (m_busy && m_cyc < m_lat && !m_err) ? m_op : 6'd0;
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("alu_signal", 32'(alu_signal), 32'(exp_sig));
            chk("alu_dataA", alu_dataA, m_a);
            chk("alu_dataB", alu_dataB, m_b);
            chk("hilo_valid", 32'(hilo_valid), 32'(m_hv));
            if (exp_rv) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Returns at the negedge where rsp_valid is first seen; lat = cycles after accept.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rr, output int lat, output int sigcnt);
        wait_idle();
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = rr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        sigcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (alu_signal == op) sigcnt++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int sc;
        int seen;
        reset = 1'b0; req_valid = 1'b0; req_op = 6'd0; req_a = 32'd0; req_b = 32'd0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_hilo", 32'(hilo_valid), 32'd0);
        chk("rst_signal", 32'(alu_signal), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);

        issue(OP_ADD, 32'd5, 32'd7, 1'b1, lat, sc);
        chk("add_lat", lat, 2);
        chk("add_data", rsp_data, 32'd12);
        chk("add_err", 32'(rsp_err), 32'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, lat, sc);
        chk("mul_lat", lat, 34);
        chk("mul_sigcycles", sc, 33);
        chk("mul_hilo", 32'(hilo_valid), 32'd1);
        chk("mul_data", rsp_data, 32'd0);

        issue(OP_MFHI, 32'd0, 32'd0, 1'b1, lat, sc);
        chk("mfhi_lat", lat, 2);
        chk("mfhi_data", rsp_data, 32'd1);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b1, lat, sc);
        chk("mflo_data", rsp_data, 32'hFFFF_FFFE);

        issue(OP_BAD, 32'd9, 32'd9, 1'b1, lat, sc);
        chk("bad_lat", lat, 1);
        chk("bad_err", 32'(rsp_err), 32'd1);
        chk("bad_data", rsp_data, 32'd0);
        chk("bad_signal", 32'(alu_signal), 32'd0);

        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, lat, sc);
        chk("slt_data", rsp_data, 32'd1);
        issue(OP_SLL, 32'd1, 32'd4, 1'b1, lat, sc);
        chk("sll_data", rsp_data, 32'd16);
        issue(OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b1, lat, sc);
        chk("and_data", rsp_data, 32'h00F0_F000);
        issue(OP_OR, 32'hF000_0001, 32'h0000_0F00, 1'b1, lat, sc);
        chk("or_data", rsp_data, 32'hF000_0F01);

        issue(OP_SUB, 32'd3, 32'd5, 1'b0, lat, sc);
        chk("sub_lat", lat, 2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("sub_hold_valid", 32'(rsp_valid), 32'd1);
            chk("sub_hold_data", rsp_data, 32'hFFFF_FFFE);
            chk("sub_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("sub_done_valid", 32'(rsp_valid), 32'd0);
        chk("sub_done_ready", 32'(req_ready), 32'd1);

        wait_idle();
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_MULTU; req_a = 32'd7; req_b = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_hilo", 32'(hilo_valid), 32'd0);
        chk("abort_signal", 32'(alu_signal), 32'd0);
        chk("abort_dataA", alu_dataA, 32'd0);
        chk("abort_dataB", alu_dataB, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);

        issue(OP_MFHI, 32'd0, 32'd0, 1'b1, lat, sc);
        chk("mfhi_nohilo_err", 32'(rsp_err), 32'd0);
        chk("mfhi_nohilo_data", rsp_data, 32'd1);
        chk("mfhi_nohilo_hv", 32'(hilo_valid), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!req_valid || acc_flag) begin
                req_valid = ($urandom % 3) != 0;
                req_op    = OPS[$urandom % 11];
                req_a     = rand_opnd();
                req_b     = rand_opnd();
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
